bist_repair_remap: RTL and testbench
====================================

Name: bist_repair_remap

Overview:
- Sits downstream of the BIST controller and between the user port and the RAM read-data path.
- During a BIST run, captures each failing address reported by the controller/comparator into a small table of spare bytes.
- After the run, redirects user writes and reads that hit a defective address into the spare storage. This gives the RAM word-level redundancy repair.
- Replaces the single-entry extra-byte patch logic with an N-entry, sticky, overflow-aware repair unit.

Parameters:
- ADDR_W, 10, RAM address width.
- DATA_W, 8, RAM data width.
- SPARES, 4, number of spare words (repair table entries); must be 1..16.
- RD_LAT, 1, RAM read latency in clk cycles; the hit/select path is delayed to match.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- tst_start  in  1  one-cycle pulse; BIST run begins.
- tst_done  in  1  one-cycle pulse; BIST run finished.
- fail_valid  in  1  comparator mismatch qualified by the controller, one per failing access.
- fail_addr  in  ADDR_W  address of the failing access.
- wrt_en  in  1  user write enable (already de-muxed from BIST).
- wrt_addrs  in  ADDR_W  user write address.
- wrt_dat  in  DATA_W  user write data.
- rd_addrs  in  ADDR_W  user read address, presented with the RAM read.
- ram_rd_data  in  DATA_W  RAM read data, RD_LAT cycles after rd_addrs.
- rd_data  out  DATA_W  repaired read data, aligned with ram_rd_data.
- repair_count  out  5  number of valid table entries.
- repair_ok  out  1  high in ACTIVE state.
- repair_overflow  out  1  sticky; more distinct failures than SPARES.
- remap_en  out  1  high when redirection is active.

Behaviour:
- Reset (rst=0 at posedge):
  - state=IDLE; all entry valid bits cleared; spare data cleared to 0.
  - repair_count=0, repair_ok=0, repair_overflow=0, remap_en=0.
  - rd_data equals ram_rd_data (pass-through) once the pipeline flushes. The delay registers clear to "no hit".
- States: IDLE, COLLECT, ACTIVE, FAILED.
  - IDLE: tst_start -> COLLECT.
  - COLLECT: table is cleared on entry (cycle of tst_start). tst_done -> ACTIVE if repair_overflow=0, else FAILED.
  - ACTIVE: remap_en=1, repair_ok=1. tst_start -> COLLECT (re-test wipes the table).
  - FAILED: remap_en=1, repair_ok=0. tst_start -> COLLECT.
  - tst_start and tst_done in the same cycle: tst_start wins.
- Capture (COLLECT only), on fail_valid:
  - Compare fail_addr with all valid entries. A hit is a duplicate and is ignored.
  - On a miss with count<SPARES, allocate the lowest free entry next cycle. The spare data initialises to 0 and repair_count increments.
  - On a miss with count==SPARES, set repair_overflow; the table is unchanged.
  - fail_valid outside COLLECT is ignored.
- Write snoop (ACTIVE or FAILED):
  - If wrt_en and wrt_addrs hits a valid entry, that spare's data <= wrt_dat.
  - The RAM write still occurs; it is harmless.
- Read (ACTIVE or FAILED):
  - rd_addrs is compared combinationally; the hit flag and entry index are pipelined RD_LAT stages.
  - On a hit, rd_data = spare data (registered spare value at delayed index); otherwise rd_data = ram_rd_data.
- Read/write same address same cycle: the read returns the old spare value, matching RAM read-before-write.
- In IDLE and COLLECT, rd_data = ram_rd_data unconditionally. BIST must see raw cells.
- Entry addresses are compared full-width; no wrap-around aliasing.
- Reset asserted mid-COLLECT discards the partial table.

Optional Feature:
- Macro: BIST_REPAIR_PARITY_EN.
- Defined:
  - Each spare stores one extra even-parity bit, computed on snoop write.
  - On a remapped read, a parity mismatch sets a sticky output port spare_par_err (1 bit, reset 0).
  - rd_data still returns the spare value.
- Undefined: no parity storage; the spare_par_err port does not exist.

Decomposition:
- Package bist_repair_pkg:
  - state enum (IDLE, COLLECT, ACTIVE, FAILED);
  - default widths;
  - localparam for the index width, $clog2(SPARES).
- Sub-module repair_cam_entry, instantiated SPARES times via generate.
  - Contains the valid bit, stored address, spare data (and parity), and three match comparators (fail, write, read).
- Top level contains the FSM, allocator priority encoder, count, and read-delay pipeline.

Test Plan:
- Reset, then tst_start; fail_valid at addr 100; tst_done -> repair_count=1, repair_ok=1. Then write 0xA5 to addr 100 and read addr 100 -> rd_data=0xA5 while ram_rd_data=0xFF.
- Fails at 5, 5, 7 in COLLECT -> repair_count=2 (duplicate dropped). A read at addr 6 passes ram_rd_data through unchanged.
- Five distinct fails (1,2,3,4,9) with SPARES=4 -> repair_overflow=1. tst_done -> FAILED, remap_en=1, addrs 1–4 remapped, addr 9 not.
- Write addr 100 and read addr 100 in the same cycle in ACTIVE -> rd_data is the old spare value; the next read returns the new value.
- rst=0 mid-COLLECT after 2 fails -> repair_count=0, state IDLE. A new tst_start/tst_done with no fails -> repair_ok=1, count=0.
- With BIST_REPAIR_PARITY_EN: force spare parity flip on entry 0, then read its address -> spare_par_err=1 and stays 1 until reset.

Source files
------------

// File: rtl/bist_repair_pkg.sv
// Shared widths, FSM state codes and helpers for the BIST repair/remap unit.
// Optional spare parity is enabled with the BIST_REPAIR_PARITY_EN macro.
package bist_repair_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 8;
  localparam int SPARES_DEF = 4;
  localparam int RD_LAT_DEF = 1;
  localparam int IDX_W_DEF  = $clog2(SPARES_DEF);
  localparam int CNT_W      = 5;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_COLLECT = 2'd1;
  localparam state_t ST_ACTIVE  = 2'd2;
  localparam state_t ST_FAILED  = 2'd3;

  // A single-spare build still needs a one-bit index.
  function automatic int idx_width(input int spares);
    return (spares > 1) ? $clog2(spares) : 1;
  endfunction

endpackage

// File: rtl/repair_cam_entry.sv
// One repair table entry: valid bit, failing address, spare word and the
// fail/write/read address comparators. Parity storage under BIST_REPAIR_PARITY_EN.
module repair_cam_entry
  import bist_repair_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              alloc_i,
  input  logic [ADDR_W-1:0] fail_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic              valid_o,
  output logic              fail_hit_o,
  output logic              wr_hit_o,
  output logic              rd_hit_o,
  output logic [DATA_W-1:0] data_o
`ifdef BIST_REPAIR_PARITY_EN
  ,
  output logic              par_o
`endif
);

  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
`ifdef BIST_REPAIR_PARITY_EN
  logic              par_q;
`endif

  assign fail_hit_o = valid_q && (addr_q == fail_addr_i);
  assign wr_hit_o   = valid_q && (addr_q == wr_addr_i);
  assign rd_hit_o   = valid_q && (addr_q == rd_addr_i);
  assign valid_o    = valid_q;
  assign data_o     = data_q;
`ifdef BIST_REPAIR_PARITY_EN
  assign par_o      = par_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  // NOTE: the spare word is a handful of flops, not a RAM macro, so it is reset like any register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef BIST_REPAIR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (clear_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
`ifdef BIST_REPAIR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (alloc_i) begin
      valid_q <= 1'b1;
      addr_q  <= fail_addr_i;
      data_q  <= '0;
`ifdef BIST_REPAIR_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else if (wr_en_i && wr_hit_o) begin
      data_q  <= wr_data_i;
`ifdef BIST_REPAIR_PARITY_EN
      par_q   <= ^wr_data_i;
`endif
    end
  end

endmodule

// File: rtl/bist_repair_remap.sv
// Word-level redundancy repair: captures BIST failing addresses into spare
// words and redirects user accesses to them. Optional BIST_REPAIR_PARITY_EN.
module bist_repair_remap
  import bist_repair_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int SPARES = SPARES_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tst_start,
  input  logic              tst_done,
  input  logic              fail_valid,
  input  logic [ADDR_W-1:0] fail_addr,
  input  logic              wrt_en,
  input  logic [ADDR_W-1:0] wrt_addrs,
  input  logic [DATA_W-1:0] wrt_dat,
  input  logic [ADDR_W-1:0] rd_addrs,
  input  logic [DATA_W-1:0] ram_rd_data,
  output logic [DATA_W-1:0] rd_data,
  output logic [CNT_W-1:0]  repair_count,
  output logic              repair_ok,
  output logic              repair_overflow,
  output logic              remap_en
`ifdef BIST_REPAIR_PARITY_EN
  ,
  output logic              spare_par_err
`endif
);

  localparam int IDX_W = idx_width(SPARES);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               in_collect, remap;
  logic               free_found;

  logic [SPARES-1:0]  valid, fail_hit, wr_hit, rd_hit, alloc_vec;
  logic [DATA_W-1:0]  spare_data [SPARES];

  logic [IDX_W-1:0]   rd_idx;
  logic               rd_any;
  logic [DATA_W-1:0]  rd_sel;
  logic               hit_pipe_q [RD_LAT];
  logic [DATA_W-1:0]  dat_pipe_q [RD_LAT];

  assign in_collect = (state_q == ST_COLLECT) && !tst_start;
  assign remap      = (state_q == ST_ACTIVE) || (state_q == ST_FAILED);

  for (genvar g = 0; g < SPARES; g++) begin : g_entry
`ifdef BIST_REPAIR_PARITY_EN
    logic par;
`endif
    repair_cam_entry #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
    ) u_entry (
      .clk        (clk),
      .rst        (rst),
      .clear_i    (tst_start),
      .alloc_i    (alloc_vec[g]),
      .fail_addr_i(fail_addr),
      .wr_en_i    (wrt_en && remap),
      .wr_addr_i  (wrt_addrs),
      .wr_data_i  (wrt_dat),
      .rd_addr_i  (rd_addrs),
      .valid_o    (valid[g]),
      .fail_hit_o (fail_hit[g]),
      .wr_hit_o   (wr_hit[g]),
      .rd_hit_o   (rd_hit[g]),
      .data_o     (spare_data[g])
`ifdef BIST_REPAIR_PARITY_EN
      ,
      .par_o      (par)
`endif
    );
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alloc_vec  = '0;
    free_found = 1'b0;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (tst_start) begin
      count_d    = '0;
      overflow_d = 1'b0;
    end else if (in_collect && fail_valid && !(|fail_hit)) begin
      if (count_q < CNT_W'(SPARES)) begin
        for (int i = 0; i < SPARES; i++) begin
          if (!valid[i] && !free_found) begin
            alloc_vec[i] = 1'b1;
            free_found   = 1'b1;
          end
        end
        count_d = count_q + 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  // A restart pulse wins over a coincident done pulse from any state.
  always_comb begin
    state_d = state_q;
    if (tst_start) begin
      state_d = ST_COLLECT;
    end else if (state_q == ST_COLLECT && tst_done) begin
      state_d = overflow_d ? ST_FAILED : ST_ACTIVE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  always_comb begin
    rd_idx = '0;
    rd_any = 1'b0;
    for (int i = 0; i < SPARES; i++) begin
      if (rd_hit[i]) begin
        rd_idx = IDX_W'(i);
        rd_any = 1'b1;
      end
    end
  end

  // The spare word is captured at read time so a same-cycle snoop write is not visible.
  assign rd_sel = spare_data[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) begin
        hit_pipe_q[i] <= 1'b0;
        dat_pipe_q[i] <= '0;
      end
    end else begin
      hit_pipe_q[0] <= remap && rd_any;
      dat_pipe_q[0] <= rd_sel;
      for (int i = 1; i < RD_LAT; i++) begin
        hit_pipe_q[i] <= hit_pipe_q[i-1];
        dat_pipe_q[i] <= dat_pipe_q[i-1];
      end
    end
  end

  assign rd_data         = (remap && hit_pipe_q[RD_LAT-1]) ? dat_pipe_q[RD_LAT-1] : ram_rd_data;
  assign repair_count    = count_q;
  assign repair_ok       = (state_q == ST_ACTIVE);
  assign repair_overflow = overflow_q;
  assign remap_en        = remap;

`ifdef BIST_REPAIR_PARITY_EN
  logic              rd_par;
  logic              bad_pipe_q [RD_LAT];
  logic              par_err_q;
  logic [SPARES-1:0] par_vec;

  for (genvar g = 0; g < SPARES; g++) begin : g_par
    assign par_vec[g] = g_entry[g].par;
  end

  assign rd_par = par_vec[rd_idx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) bad_pipe_q[i] <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      bad_pipe_q[0] <= remap && rd_any && ((^rd_sel) != rd_par);
      for (int i = 1; i < RD_LAT; i++) bad_pipe_q[i] <= bad_pipe_q[i-1];
      if (remap && bad_pipe_q[RD_LAT-1]) par_err_q <= 1'b1;
    end
  end

  assign spare_par_err = par_err_q;
`endif

endmodule

// File: tb/tb_bist_repair_remap.sv
// Directed bench for bist_repair_remap: a table-level reference model checked
// every cycle, plus literal expectations from the test plan.
module tb_bist_repair_remap;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int SPARES = 4;
  localparam int RD_LAT = 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              tst_start, tst_done, fail_valid, wrt_en;
  logic [ADDR_W-1:0] fail_addr, wrt_addrs, rd_addrs;
  logic [DATA_W-1:0] wrt_dat, ram_rd_data, ram_next;
  logic [DATA_W-1:0] rd_data;
  logic [4:0]        repair_count;
  logic              repair_ok, repair_overflow, remap_en;
`ifdef BIST_REPAIR_PARITY_EN
  logic              spare_par_err;
`endif

  int n_checks = 0;
  int n_errors = 0;

  bist_repair_remap #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SPARES(SPARES), .RD_LAT(RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .tst_start      (tst_start),
    .tst_done       (tst_done),
    .fail_valid     (fail_valid),
    .fail_addr      (fail_addr),
    .wrt_en         (wrt_en),
    .wrt_addrs      (wrt_addrs),
    .wrt_dat        (wrt_dat),
    .rd_addrs       (rd_addrs),
    .ram_rd_data    (ram_rd_data),
    .rd_data        (rd_data),
    .repair_count   (repair_count),
    .repair_ok      (repair_ok),
    .repair_overflow(repair_overflow),
    .remap_en       (remap_en)
`ifdef BIST_REPAIR_PARITY_EN
    ,
    .spare_par_err  (spare_par_err)
`endif
  );

  always #5 clk = ~clk;

  // Stand-in RAM: the read word appears one cycle after the address.
  always @(posedge clk) ram_rd_data <= ram_next;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: repair table as a list of (address, word) pairs.
  typedef enum {M_IDLE, M_COLLECT, M_ACTIVE, M_FAILED} m_state_e;
  m_state_e          m_state;
  int unsigned       m_addr [$];
  logic [DATA_W-1:0] m_data [$];
  bit                m_ovf;
  logic [DATA_W-1:0] exp_rd;

  function automatic int m_find(input int unsigned a);
    for (int i = 0; i < m_addr.size(); i++) if (m_addr[i] == a) return i;
    return -1;
  endfunction

  always @(posedge clk) begin
    bit pre_remap;
    int ri, wi;
    pre_remap = (m_state == M_ACTIVE) || (m_state == M_FAILED);
    ri = m_find(rd_addrs);
    exp_rd = (pre_remap && ri >= 0) ? m_data[ri] : ram_next;
    if (!rst) begin
      m_state = M_IDLE;
      m_addr.delete();
      m_data.delete();
      m_ovf = 1'b0;
    end else begin
      if (pre_remap && wrt_en) begin
        wi = m_find(wrt_addrs);
        if (wi >= 0) m_data[wi] = wrt_dat;
      end
      if (tst_start) begin
        m_addr.delete();
        m_data.delete();
        m_ovf   = 1'b0;
        m_state = M_COLLECT;
      end else if (m_state == M_COLLECT) begin
        if (fail_valid && m_find(fail_addr) < 0) begin
          if (m_addr.size() < SPARES) begin
            m_addr.push_back(fail_addr);
            m_data.push_back('0);
          end else begin
            m_ovf = 1'b1;
          end
        end
        if (tst_done) m_state = m_ovf ? M_FAILED : M_ACTIVE;
      end
    end
    if (!(m_state == M_ACTIVE || m_state == M_FAILED)) exp_rd = ram_next;
    #1;
    check("mdl_rd_data", rd_data, exp_rd);
    check("mdl_count", repair_count, m_addr.size());
    check("mdl_ok", repair_ok, m_state == M_ACTIVE);
    check("mdl_overflow", repair_overflow, m_ovf);
    check("mdl_remap_en", remap_en, (m_state == M_ACTIVE) || (m_state == M_FAILED));
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic pulse_start();
    tst_start = 1'b1; tick(); tst_start = 1'b0;
  endtask

  task automatic pulse_done();
    tst_done = 1'b1; tick(); tst_done = 1'b0;
  endtask

  task automatic fail_at(input logic [ADDR_W-1:0] a);
    fail_valid = 1'b1; fail_addr = a; tick(); fail_valid = 1'b0;
  endtask

  task automatic write_at(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    wrt_en = 1'b1; wrt_addrs = a; wrt_dat = d; tick(); wrt_en = 1'b0;
  endtask

  // Leaves the read result on rd_data when it returns.
  task automatic read_at(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] ram_word);
    rd_addrs = a; ram_next = ram_word; tick(); rd_addrs = 10'h3FF; ram_next = 8'hFF;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0; tst_start = 1'b0; tst_done = 1'b0; fail_valid = 1'b0;
    fail_addr = '0; wrt_en = 1'b0; wrt_addrs = '0; wrt_dat = '0;
    rd_addrs = 10'h3FF; ram_next = 8'hFF;
    repeat (3) tick();
    check("rst_count", repair_count, 0);
    check("rst_ok", repair_ok, 0);
    check("rst_overflow", repair_overflow, 0);
    check("rst_remap", remap_en, 0);
    check("rst_rd_pass", rd_data, 8'hFF);
    rst = 1'b1;
    tick();

    fail_at(10'd50);
    check("idle_fail_ignored", repair_count, 0);

    // Single repair, snoop write, remapped read.
    pulse_start();
    fail_at(10'd100);
    pulse_done();
    check("t1_count", repair_count, 1);
    check("t1_ok", repair_ok, 1);
    write_at(10'd100, 8'hA5);
    read_at(10'd100, 8'hFF);
    check("t1_rd_spare", rd_data, 8'hA5);
`ifdef BIST_REPAIR_PARITY_EN
    check("t1_par_clean", spare_par_err, 0);
`endif

    // Duplicate failure dropped; unrepaired address passes through.
    pulse_start();
    fail_at(10'd5);
    fail_at(10'd5);
    fail_at(10'd7);
    pulse_done();
    check("t2_count", repair_count, 2);
    read_at(10'd6, 8'h3C);
    check("t2_rd_pass", rd_data, 8'h3C);
    read_at(10'd5, 8'h3C);
    check("t2_rd_fresh_spare", rd_data, 8'h00);

    // Overflow: five distinct failures into four spares.
    pulse_start();
    fail_at(10'd1); fail_at(10'd2); fail_at(10'd3); fail_at(10'd4);
    check("t3_full_no_ovf", repair_overflow, 0);
    fail_at(10'd9);
    check("t3_overflow", repair_overflow, 1);
    check("t3_count_sat", repair_count, 4);
    pulse_done();
    check("t3_remap", remap_en, 1);
    check("t3_not_ok", repair_ok, 0);
    for (int a = 1; a <= 4; a++) begin
      write_at(ADDR_W'(a), DATA_W'(8'h10 + a));
      read_at(ADDR_W'(a), 8'h77);
      check("t3_rd_remapped", rd_data, 8'h10 + a);
    end
    read_at(10'd9, 8'h77);
    check("t3_rd_9_pass", rd_data, 8'h77);
    fail_at(10'd20);
    check("t3_failed_ignores_fail", repair_count, 4);

    // Read-before-write on the same address in one cycle.
    pulse_start();
    fail_at(10'd100);
    pulse_done();
    check("t4_ok", repair_ok, 1);
    write_at(10'd100, 8'hA5);
    wrt_en = 1'b1; wrt_addrs = 10'd100; wrt_dat = 8'h5A;
    rd_addrs = 10'd100; ram_next = 8'hFF;
    tick();
    wrt_en = 1'b0;
    check("t4_rd_old", rd_data, 8'hA5);
    tick();
    rd_addrs = 10'h3FF;
    check("t4_rd_new", rd_data, 8'h5A);
    tick();

    // Coincident start and done: start wins and the table is wiped.
    tst_start = 1'b1; tst_done = 1'b1; tick();
    tst_start = 1'b0; tst_done = 1'b0;
    check("t6_collect_ok", repair_ok, 0);
    check("t6_collect_remap", remap_en, 0);
    check("t6_wiped", repair_count, 0);
    read_at(10'd100, 8'h42);
    check("t6_collect_raw", rd_data, 8'h42);

    // Reset mid-collection discards the partial table.
    fail_at(10'd5);
    fail_at(10'd6);
    check("t5_partial", repair_count, 2);
    rst = 1'b0; tick(); rst = 1'b1;
    check("t5_rst_count", repair_count, 0);
    check("t5_rst_remap", remap_en, 0);
    fail_at(10'd8);
    check("t5_idle_after_rst", repair_count, 0);
    pulse_start();
    pulse_done();
    check("t5_empty_ok", repair_ok, 1);
    check("t5_empty_count", repair_count, 0);

`ifdef BIST_REPAIR_PARITY_EN
    pulse_start();
    fail_at(10'd200);
    pulse_done();
    force dut.g_entry[0].u_entry.par_q = 1'b1;
    tick();
    read_at(10'd200, 8'hFF);
    release dut.g_entry[0].u_entry.par_q;
    tick();
    check("par_err_set", spare_par_err, 1);
    repeat (3) tick();
    check("par_err_sticky", spare_par_err, 1);
    rst = 1'b0; tick(); rst = 1'b1;
    check("par_err_rst", spare_par_err, 0);
`endif

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
